// File: rtl/sbox_share_ctrl_pkg.sv
// Shared definitions for the time-multiplexed S-box scheduler: the forward
// AES S-box table, the scheduler FSM states and the requester identifiers.
package sbox_share_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ST_RUN,
      S_KEY_RUN
   } fsm_state_e;

   typedef enum logic {
      GRANT_STATE,
      GRANT_KEY
   } grant_e;

   // Forward AES S-box, FIPS-197 order (entry n is S(n)).
   localparam logic [7:0] SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Single-byte forward substitution.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return SBOX_FWD[b];
   endfunction

endpackage

// File: rtl/sbox_share_ctrl_lane.sv
// LANES-byte combinational substitution lane. Each byte goes through its own
// table lookup; an inverse-cipher build swaps the lookup function only.
module sbox_share_ctrl_lane
   import sbox_share_ctrl_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic [0:LANES*8-1] i_bytes,
   output logic [0:LANES*8-1] o_bytes
);

   // Byte-parallel lookups; byte g occupies bits [8g +: 8].
   for (genvar g = 0; g < LANES; g++) begin : g_byte
      assign o_bytes[g*8 +: 8] = sbox_fwd(i_bytes[g*8 +: 8]);
   end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one LANES-byte S-box lane between the round datapath (16-byte
// SubBytes, BEATS = 16/LANES cycles) and the key schedule (4-byte SubWord).
// Arbitration is non-preemptive with alternating priority on ties.
module sbox_share_ctrl
   import sbox_share_ctrl_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_st_req,
   input  logic [0:127]  i_st_in,
   output logic          o_st_done,
   output logic [0:127]  o_st_out,
   input  logic          i_key_req,
   input  logic [0:31]   i_key_in,
   output logic          o_key_done,
   output logic [0:31]   o_key_out,
   output logic          o_busy
);

   localparam int BEATS  = 16 / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LANE_W = LANES * 8;

   fsm_state_e          r_state;
   grant_e              r_last_grant;
   logic [BEAT_W-1:0]   r_beat;
   logic [0:127]        r_buf;
   logic [0:127]        r_st_out;
   logic [0:31]         r_key_out;
   logic                r_st_done;
   logic                r_key_done;
   logic                r_busy;

   logic                w_st_eff;
   logic                w_key_eff;
   logic                w_pick_key;
   logic [0:LANE_W-1]   w_lane_in;
   logic [0:LANE_W-1]   w_lane_out;

   // A requester is masked in the cycle its done pulse is high, so a level-held
   // req is not regranted before the requester has seen completion. On a tie
   // the side that did not win last time goes first.
   assign w_st_eff   = i_st_req  & ~r_st_done;
   assign w_key_eff  = i_key_req & ~r_key_done;
   assign w_pick_key = w_key_eff & (~w_st_eff | (r_last_grant == GRANT_STATE));

   // The current beat's slice of the job buffer feeds the lane; a key job sits
   // in the low word of the buffer with beat 0.
   assign w_lane_in = r_buf[int'(r_beat)*LANE_W +: LANE_W];

   sbox_share_ctrl_lane #(
      .LANES (LANES)
   ) u_lane (
      .i_bytes (w_lane_in),
      .o_bytes (w_lane_out)
   );

   // Scheduler FSM with registered done pulses, outputs and busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= GRANT_STATE;
         r_beat       <= '0;
         r_buf        <= '0;
         r_st_out     <= '0;
         r_key_out    <= '0;
         r_st_done    <= 1'b0;
         r_key_done   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below sees
         // the pre-edge values and the default pulse clear is simply overridden.
         r_st_done  <= 1'b0;
         r_key_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick_key) begin
                  r_buf        <= {i_key_in, 96'd0};
                  r_last_grant <= GRANT_KEY;
                  r_beat       <= '0;
                  r_busy       <= 1'b1;
                  r_state      <= S_KEY_RUN;
               end else if (w_st_eff) begin
                  r_buf        <= i_st_in;
                  r_last_grant <= GRANT_STATE;
                  r_beat       <= '0;
                  r_busy       <= 1'b1;
                  r_state      <= S_ST_RUN;
               end
            end
            S_ST_RUN: begin
               r_st_out[int'(r_beat)*LANE_W +: LANE_W] <= w_lane_out;
               if (r_beat == BEAT_W'(BEATS - 1)) begin
                  r_st_done <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
            S_KEY_RUN: begin
               r_key_out  <= w_lane_out[0:31];
               r_key_done <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_st_done  = r_st_done;
   assign o_st_out   = r_st_out;
   assign o_key_done = r_key_done;
   assign o_key_out  = r_key_out;
   assign o_busy     = r_busy;

endmodule
